// File: rtl/rr_core_arbiter.sv
// rr_core_arbiter: work-conserving round-robin arbiter for one shared resource.
// Holds a registered one-hot grant until the resource pulses done, or until a
// hold watchdog expires. A one-cycle release bubble follows every grant.
module rr_core_arbiter #(
    parameter int NUM_OF_CORES = 4,
    parameter int MAX_HOLD     = 64,
    parameter int ID_W         = $clog2(NUM_OF_CORES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_OF_CORES-1:0] request_vector,
    input  logic                    done,
    output logic [NUM_OF_CORES-1:0] grant,
    output logic                    grant_valid,
    output logic [ID_W-1:0]         grant_id,
    output logic                    timeout_err
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [NUM_OF_CORES-1:0] grant_reg;
    logic [ID_W-1:0]         grant_id_reg;
    logic [ID_W-1:0]         ptr_reg;
    logic [HC_W-1:0]         hold_cnt_reg;
    logic                    timeout_err_reg;

    logic                    winner_found;
    logic [ID_W-1:0]         winner_idx;
    logic [ID_W:0]           cand;
    logic [ID_W-1:0]         ptr_next;
    logic [NUM_OF_CORES-1:0] winner_onehot;

    // Scan requests starting at ptr and wrapping; walking offsets from the
    // far end down means the nearest requester is the last one written.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        cand         = '0;
        for (int k = NUM_OF_CORES - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_OF_CORES)) begin
                cand = cand - (ID_W+1)'(NUM_OF_CORES);
            end
            if (request_vector[cand[ID_W-1:0]]) begin
                winner_found = 1'b1;
                winner_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Pointer moves just past the winner; explicit wrap keeps odd core counts correct.
    always_comb begin
        if (winner_idx == ID_W'(NUM_OF_CORES - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = winner_idx + 1'b1;
        end
    end

    // One-hot decode of the winning index.
    generate
        for (genvar gi = 0; gi < NUM_OF_CORES; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner_idx == ID_W'(gi));
        end
    endgenerate

    // Arbitration FSM: grant selection, hold watchdog and release bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= '0;
            grant_id_reg    <= '0;
            ptr_reg         <= '0;
            hold_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (winner_found) begin
                        grant_reg    <= winner_onehot;
                        grant_id_reg <= winner_idx;
                        ptr_reg      <= ptr_next;
                        hold_cnt_reg <= '0;
                        state_reg    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Counter stops once we leave GRANT, so it tops out at MAX_HOLD.
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    if (done) begin
                        grant_reg <= '0;
                        state_reg <= ST_RELEASE;
                    end else if (hold_cnt_reg == HC_W'(MAX_HOLD - 1)) begin
                        grant_reg       <= '0;
                        timeout_err_reg <= 1'b1;
                        state_reg       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = |grant_reg;
    assign grant_id    = grant_id_reg;
    assign timeout_err = timeout_err_reg;

endmodule
